// File: rtl/landing_gear_pkg.sv
// Shared types for the multi-leg landing gear controller.
// Holds the state encoding (TAXI must stay 0) and the lever polarity.
package landing_gear_pkg;

    typedef enum logic [2:0] {
        TAXI  = 3'd0,
        TUP   = 3'd1,
        TDN   = 3'd2,
        GOUP  = 3'd3,
        FLYUP = 3'd4,
        GODN  = 3'd5,
        FLYDN = 3'd6,
        FAULT = 3'd7
    } gear_state_e;

    localparam logic LEVER_DN = 1'b1;
    localparam logic LEVER_UP = 1'b0;

endpackage

// File: rtl/landing_gear_array_ctrl_if.sv
// Cockpit/sensor inputs and pump/valve/indicator outputs of the gear controller.
// The controller uses the slave side; the cockpit/harness side uses master.
interface landing_gear_array_ctrl_if #(
    parameter int N_LEGS = 3
);
    logic [N_LEGS-1:0] GearIsDown;
    logic [N_LEGS-1:0] GearIsUp;
    logic              PlaneOnGround;
    logic              Lever;
    logic              RedLED;
    logic              GrnLED;
    logic              Valve;
    logic              Pump;
    logic              Fault;
    logic [N_LEGS-1:0] FaultLegs;
    logic [2:0]        StateOut;

    modport master (
        output GearIsDown, GearIsUp, PlaneOnGround, Lever,
        input  RedLED, GrnLED, Valve, Pump, Fault, FaultLegs, StateOut
    );

    modport slave (
        input  GearIsDown, GearIsUp, PlaneOnGround, Lever,
        output RedLED, GrnLED, Valve, Pump, Fault, FaultLegs, StateOut
    );
endinterface

// File: rtl/gear_cycle_timer.sv
// Loadable saturating counter: counts toward TERMINAL (up or down) and holds there.
// done is asserted while the count sits at TERMINAL.
module gear_cycle_timer #(
    parameter int          WIDTH    = 4,
    parameter bit          COUNT_UP = 1'b1,
    parameter int unsigned TERMINAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == WIDTH'(TERMINAL));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!done) begin
            cnt_d = COUNT_UP ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/landing_gear_array_ctrl.sv
// Multi-leg landing gear sequencer with lift-off hold, transit watchdog and
// per-leg sensor-conflict detection; any fault latches and forces extension.
module landing_gear_array_ctrl
    import landing_gear_pkg::*;
#(
    parameter int N_LEGS        = 3,
    parameter int TAXI_HOLD     = 4,
    parameter int TRANSIT_LIMIT = 16
) (
    input  logic                     Clock,
    input  logic                     Clear,
    landing_gear_array_ctrl_if.slave bus
);
    localparam int HOLD_W = $clog2(TAXI_HOLD + 1);
    localparam int WD_W   = $clog2(TRANSIT_LIMIT);

    gear_state_e       state_q, state_d;
    logic [N_LEGS-1:0] fault_legs_q, fault_legs_d;
    logic [N_LEGS-1:0] conflict;
    logic              all_up, all_down, lever_dn;
    logic              hold_done, wd_done, in_transit;

    assign all_up     = &bus.GearIsUp;
    assign all_down   = &bus.GearIsDown;
    assign conflict   = bus.GearIsUp & bus.GearIsDown;
    assign lever_dn   = (bus.Lever == LEVER_DN);
    assign in_transit = (state_q == GOUP) || (state_q == GODN);

    // Hold timer is reloaded every TAXI cycle, so a TUP/TDN swap keeps counting down.
    gear_cycle_timer #(.WIDTH(HOLD_W), .COUNT_UP(1'b0), .TERMINAL(0)) u_hold (
        .clk      (Clock),
        .rst      (Clear),
        .load     (state_q == TAXI),
        .load_val (HOLD_W'(TAXI_HOLD - 1)),
        .done     (hold_done)
    );

    // Watchdog sits at zero outside transit, so it starts from zero on every entry.
    gear_cycle_timer #(.WIDTH(WD_W), .COUNT_UP(1'b1), .TERMINAL(TRANSIT_LIMIT - 1)) u_wd (
        .clk      (Clock),
        .rst      (Clear),
        .load     (!in_transit),
        .load_val ('0),
        .done     (wd_done)
    );

    always_comb begin
        state_d      = state_q;
        fault_legs_d = fault_legs_q;
        if (state_q != FAULT && |conflict) begin
            state_d      = FAULT;
            fault_legs_d = conflict;
        end else begin
            unique case (state_q)
                TAXI:  if (!bus.PlaneOnGround) state_d = lever_dn ? TDN : TUP;
                TUP:   if (bus.PlaneOnGround) state_d = TAXI;
                       else if (hold_done)    state_d = GOUP;
                       else if (lever_dn)     state_d = TDN;
                TDN:   if (bus.PlaneOnGround) state_d = TAXI;
                       else if (hold_done)    state_d = FLYDN;
                       else if (!lever_dn)    state_d = TUP;
                GOUP:  if (all_up) state_d = FLYUP;
                       else if (wd_done) begin
                           state_d      = FAULT;
                           fault_legs_d = ~bus.GearIsUp;
                       end
                FLYUP: if (lever_dn) state_d = GODN;
                GODN:  if (all_down) state_d = FLYDN;
                       else if (wd_done) begin
                           state_d      = FAULT;
                           fault_legs_d = ~bus.GearIsDown;
                       end
                FLYDN: if (bus.PlaneOnGround) state_d = TAXI;
                       else if (!lever_dn)    state_d = GOUP;
                FAULT: state_d = FAULT;
                default: state_d = FAULT;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q      <= TAXI;
            fault_legs_q <= '0;
        end else begin
            state_q      <= state_d;
            fault_legs_q <= fault_legs_d;
        end
    end

    // FAULT keeps pumping on the extend path until every leg reports down.
    assign bus.RedLED    = in_transit || (state_q == FAULT);
    assign bus.GrnLED    = (state_q == TAXI) || (state_q == TUP) || (state_q == TDN) ||
                           (state_q == FLYDN) || ((state_q == FAULT) && all_down);
    assign bus.Pump      = in_transit || ((state_q == FAULT) && !all_down);
    assign bus.Valve     = (state_q == GOUP);
    assign bus.Fault     = (state_q == FAULT);
    assign bus.FaultLegs = fault_legs_q;
    assign bus.StateOut  = state_q;
endmodule

// File: tb/tb_landing_gear_array_ctrl.sv
// Directed scenarios followed by random traffic, all checked every cycle against
// a cycles-in-phase reference model of the gear controller.
module tb_landing_gear_array_ctrl;
    import landing_gear_pkg::*;

    localparam int N  = 3;
    localparam int TH = 4;
    localparam int TL = 16;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fails;

    landing_gear_array_ctrl_if #(.N_LEGS(N)) gif ();

    landing_gear_array_ctrl #(.N_LEGS(N), .TAXI_HOLD(TH), .TRANSIT_LIMIT(TL)) dut (
        .Clock (clk),
        .Clear (clr),
        .bus   (gif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase plus number of cycles spent in it (TUP/TDN count as one phase).
    gear_state_e m_st;
    int          m_cnt;
    logic [N-1:0] m_legs;

    task automatic model_step();
        gear_state_e  ns;
        logic [N-1:0] up, dn, conf;
        bit           stay;
        up = gif.GearIsUp;
        dn = gif.GearIsDown;
        conf = up & dn;
        ns = m_st;
        if (clr) begin
            m_st = TAXI; m_cnt = 1; m_legs = '0;
            return;
        end
        if (m_st != FAULT && conf != '0) begin
            ns = FAULT; m_legs = conf;
        end else begin
            case (m_st)
                TAXI:    if (!gif.PlaneOnGround) ns = gif.Lever ? TDN : TUP;
                TUP, TDN: begin
                    if (gif.PlaneOnGround)   ns = TAXI;
                    else if (m_cnt == TH)    ns = (m_st == TUP) ? GOUP : FLYDN;
                    else                     ns = gif.Lever ? TDN : TUP;
                end
                GOUP: begin
                    if (&up) ns = FLYUP;
                    else if (m_cnt == TL) begin ns = FAULT; m_legs = ~up; end
                end
                FLYUP:   if (gif.Lever) ns = GODN;
                GODN: begin
                    if (&dn) ns = FLYDN;
                    else if (m_cnt == TL) begin ns = FAULT; m_legs = ~dn; end
                end
                FLYDN: begin
                    if (gif.PlaneOnGround) ns = TAXI;
                    else if (!gif.Lever)   ns = GOUP;
                end
                default: ns = FAULT;
            endcase
        end
        stay = (ns == m_st) ||
               ((m_st == TUP || m_st == TDN) && (ns == TUP || ns == TDN));
        m_cnt = stay ? m_cnt + 1 : 1;
        m_st  = ns;
    endtask

    function automatic logic [10:0] pk(gear_state_e s, logic r, logic g, logic p,
                                       logic v, logic f, logic [N-1:0] l);
        return {s, r, g, p, v, f, l};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {gif.StateOut, gif.RedLED, gif.GrnLED, gif.Pump, gif.Valve,
                gif.Fault, gif.FaultLegs};
    endfunction

    function automatic logic [10:0] model_outs();
        logic ad;
        ad = &gif.GearIsDown;
        return pk(m_st,
                  m_st == GOUP || m_st == GODN || m_st == FAULT,
                  m_st == TAXI || m_st == TUP || m_st == TDN || m_st == FLYDN ||
                      (m_st == FAULT && ad),
                  m_st == GOUP || m_st == GODN || (m_st == FAULT && !ad),
                  m_st == GOUP,
                  m_st == FAULT,
                  m_legs);
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model", dut_outs(), model_outs());
    endtask

    task automatic set_in(logic [N-1:0] dn, logic [N-1:0] up, logic gnd, logic lev);
        gif.GearIsDown = dn;
        gif.GearIsUp = up;
        gif.PlaneOnGround = gnd;
        gif.Lever = lev;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_st = TAXI; m_cnt = 1; m_legs = '0;

        // Reset, then lift off with lever up: 4 hold cycles then retract
        clr = 1'b1;
        set_in(3'b111, 3'b000, 1'b1, LEVER_UP);
        tick();
        chk("reset", dut_outs(), pk(TAXI, 0, 1, 0, 0, 0, 3'b000));
        clr = 1'b0;
        tick();
        gif.PlaneOnGround = 1'b0;
        repeat (4) tick();
        chk("hold_tup4", dut_outs(), pk(TUP, 0, 1, 0, 0, 0, 3'b000));
        tick();
        chk("goup", dut_outs(), pk(GOUP, 1, 0, 1, 1, 0, 3'b000));

        // Leg 2 never locks up: watchdog trips on the 16th GOUP cycle
        set_in(3'b000, 3'b011, 1'b0, LEVER_UP);
        repeat (15) tick();
        chk("goup_c16", dut_outs(), pk(GOUP, 1, 0, 1, 1, 0, 3'b000));
        tick();
        chk("wd_fault", dut_outs(), pk(FAULT, 1, 0, 1, 0, 1, 3'b100));

        // Clear from FAULT
        clr = 1'b1;
        set_in(3'b111, 3'b000, 1'b1, LEVER_UP);
        tick();
        chk("clr_fault", dut_outs(), pk(TAXI, 0, 1, 0, 0, 0, 3'b000));
        clr = 1'b0;

        // Full up/down cycle
        gif.PlaneOnGround = 1'b0;
        repeat (5) tick();
        set_in(3'b000, 3'b000, 1'b0, LEVER_UP);
        repeat (4) tick();
        gif.GearIsUp = 3'b111;
        tick();
        chk("flyup", dut_outs(), pk(FLYUP, 0, 0, 0, 0, 0, 3'b000));
        gif.Lever = LEVER_DN;
        tick();
        chk("godn", dut_outs(), pk(GODN, 1, 0, 1, 0, 0, 3'b000));
        gif.GearIsUp = 3'b000;
        tick();
        gif.GearIsDown = 3'b111;
        tick();
        chk("flydn", dut_outs(), pk(FLYDN, 0, 1, 0, 0, 0, 3'b000));
        gif.PlaneOnGround = 1'b1;
        tick();
        chk("land", dut_outs(), pk(TAXI, 0, 1, 0, 0, 0, 3'b000));

        // Lever toggling during hold does not reload the timer
        set_in(3'b111, 3'b000, 1'b0, LEVER_UP);
        tick();
        gif.Lever = LEVER_DN; tick();
        gif.Lever = LEVER_UP; tick();
        gif.Lever = LEVER_DN; tick();
        chk("swap_tdn", dut_outs(), pk(TDN, 0, 1, 0, 0, 0, 3'b000));
        gif.Lever = LEVER_UP;
        tick();
        chk("swap_exit", dut_outs(), pk(FLYDN, 0, 1, 0, 0, 0, 3'b000));
        gif.GearIsDown = 3'b000;
        tick();
        chk("flydn_goup", dut_outs(), pk(GOUP, 1, 0, 1, 1, 0, 3'b000));
        gif.GearIsUp = 3'b111;
        tick();

        // Leg 1 sensor conflict in FLYUP; FAULT then ignores everything
        gif.GearIsDown = 3'b010;
        tick();
        chk("conflict", dut_outs(), pk(FAULT, 1, 0, 1, 0, 1, 3'b010));
        set_in(3'b111, 3'b000, 1'b1, LEVER_DN);
        tick();
        chk("fault_hold1", dut_outs(), pk(FAULT, 1, 1, 0, 0, 1, 3'b010));
        set_in(3'b101, 3'b101, 1'b0, LEVER_UP);
        tick();
        chk("fault_hold2", dut_outs(), pk(FAULT, 1, 0, 1, 0, 1, 3'b010));
        clr = 1'b1;
        tick();
        chk("clr_fault2", dut_outs(), pk(TAXI, 0, 1, 0, 0, 0, 3'b000));
        clr = 1'b0;

        // Clear mid-GOUP
        set_in(3'b111, 3'b000, 1'b0, LEVER_UP);
        repeat (7) tick();
        clr = 1'b1;
        tick();
        chk("clr_goup", dut_outs(), pk(TAXI, 0, 1, 0, 0, 0, 3'b000));
        clr = 1'b0;

        // all_up on the watchdog expiry cycle wins
        repeat (5) tick();
        gif.GearIsDown = 3'b000;
        repeat (15) tick();
        gif.GearIsUp = 3'b111;
        tick();
        chk("up_vs_wd", dut_outs(), pk(FLYUP, 0, 0, 0, 0, 0, 3'b000));

        // GODN watchdog expiry with leg 0 stuck
        gif.Lever = LEVER_DN;
        tick();
        set_in(3'b110, 3'b000, 1'b0, LEVER_DN);
        repeat (15) tick();
        tick();
        chk("godn_wd", dut_outs(), pk(FAULT, 1, 0, 1, 0, 1, 3'b001));

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 7);
            clr = ($urandom_range(0, 79) == 0);
            case (r)
                0, 1, 2: begin gif.GearIsUp = 3'b111; gif.GearIsDown = 3'b000; end
                3, 4, 5: begin gif.GearIsUp = 3'b000; gif.GearIsDown = 3'b111; end
                6:       begin gif.GearIsUp = 3'($urandom); gif.GearIsDown = 3'b000; end
                default: begin
                    gif.GearIsUp = 3'($urandom);
                    gif.GearIsDown = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
                end
            endcase
            if ($urandom_range(0, 7) == 0) gif.PlaneOnGround = ~gif.PlaneOnGround;
            if ($urandom_range(0, 3) == 0) gif.Lever = ~gif.Lever;
            tick();
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
